// File: rtl/vx_tcu_uop_seq_pkg.sv
// rtl/vx_tcu_uop_seq_pkg.sv - shared TCU constants, micro-op record and sequencer state type
//
// Purpose : tile step counts, register bases, index widths and the micro-op
//           record used by the WMMA micro-op sequencer.
// Ports   : none (package).
package vx_tcu_uop_seq_pkg;

    localparam int TCU_M_STEPS      = 2;
    localparam int TCU_N_STEPS      = 4;
    localparam int TCU_K_STEPS      = 4;
    localparam int TCU_B_SUB_BLOCKS = 2;
    localparam int TCU_RA           = 0;
    localparam int TCU_RB           = 10;
    localparam int TCU_RC           = 24;

    // Register index width, plus record field widths wide enough for any
    // step count up to 16; the sequencer trims them to its own widths.
    localparam int TCU_IDX_W  = 5;
    localparam int TCU_STEP_W = 4;
    localparam int TCU_BSUB_W = 4;

    typedef struct packed {
        logic [TCU_STEP_W-1:0] step_m;
        logic [TCU_STEP_W-1:0] step_n;
        logic [TCU_STEP_W-1:0] step_k;
        logic [TCU_IDX_W-1:0]  rs1;
        logic [TCU_IDX_W-1:0]  rs2;
        logic [TCU_BSUB_W-1:0] b_sub;
        logic [TCU_IDX_W-1:0]  rd;
        logic                  first;
        logic                  last;
    } tcu_uop_t;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_BUSY = 1'b1
    } seq_state_e;

endpackage

// File: rtl/vx_tcu_step_ctr.sv
// rtl/vx_tcu_step_ctr.sv - nested m/n/k wrap counter, k fastest
//
// Purpose : three-level step counter. i_clear zeroes it (priority over
//           i_advance); i_advance steps k, carrying into n then m.
// Ports   : clk, reset (sync, active-high), i_clear, i_advance,
//           o_m_nxt/o_n_nxt/o_k_nxt (values the counter takes at the next
//           edge), o_last (current position is the final step).
module vx_tcu_step_ctr #(
    parameter int M_STEPS = 2,
    parameter int N_STEPS = 4,
    parameter int K_STEPS = 4,
    localparam int MW = (M_STEPS > 1) ? $clog2(M_STEPS) : 1,
    localparam int NW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1,
    localparam int KW = (K_STEPS > 1) ? $clog2(K_STEPS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [MW-1:0] o_m_nxt,
    output logic [NW-1:0] o_n_nxt,
    output logic [KW-1:0] o_k_nxt,
    output logic          o_last
);

    logic [MW-1:0] r_m;
    logic [NW-1:0] r_n;
    logic [KW-1:0] r_k;
    logic          w_m_wrap;
    logic          w_n_wrap;
    logic          w_k_wrap;

    assign w_m_wrap = (r_m == MW'(M_STEPS - 1));
    assign w_n_wrap = (r_n == NW'(N_STEPS - 1));
    assign w_k_wrap = (r_k == KW'(K_STEPS - 1));
    assign o_last   = w_m_wrap && w_n_wrap && w_k_wrap;

    always_comb begin
        o_m_nxt = r_m;
        o_n_nxt = r_n;
        o_k_nxt = r_k;
        if (i_clear) begin
            o_m_nxt = '0;
            o_n_nxt = '0;
            o_k_nxt = '0;
        end else if (i_advance) begin
            if (w_k_wrap) begin
                o_k_nxt = '0;
                if (w_n_wrap) begin
                    o_n_nxt = '0;
                    o_m_nxt = w_m_wrap ? '0 : r_m + MW'(1);
                end else begin
                    o_n_nxt = r_n + NW'(1);
                end
            end else begin
                o_k_nxt = r_k + KW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m <= '0;
            r_n <= '0;
            r_k <= '0;
        end else begin
            r_m <= o_m_nxt;
            r_n <= o_n_nxt;
            r_k <= o_k_nxt;
        end
    end

endmodule

// File: rtl/vx_tcu_uop_seq.sv
// rtl/vx_tcu_uop_seq.sv - WMMA instruction to per-step micro-op sequencer
//
// Purpose : accepts one WMMA instruction and emits M*N*K micro-ops, one per
//           accepted cycle, each with step indices and derived A/B/C regs.
// Ports   : clk, reset (sync, active-high)
//           in_valid/in_ready, in_uuid/in_wid/in_fmt_s/in_fmt_d : instruction
//           out_valid/out_ready : micro-op handshake
//           out_uuid/out_wid/out_fmt_s/out_fmt_d : latched instruction fields
//           out_step_m/n/k, out_rs1, out_rs2, out_b_sub, out_rd,
//           out_first, out_last : registered micro-op fields
module vx_tcu_uop_seq
    import vx_tcu_uop_seq_pkg::*;
#(
    parameter int M_STEPS      = TCU_M_STEPS,
    parameter int N_STEPS      = TCU_N_STEPS,
    parameter int K_STEPS      = TCU_K_STEPS,
    parameter int B_SUB_BLOCKS = TCU_B_SUB_BLOCKS,
    parameter int RA           = TCU_RA,
    parameter int RB           = TCU_RB,
    parameter int RC           = TCU_RC,
    parameter int UUID_W       = 44,
    parameter int WID_W        = 2,
    localparam int MW = (M_STEPS > 1) ? $clog2(M_STEPS) : 1,
    localparam int NW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1,
    localparam int KW = (K_STEPS > 1) ? $clog2(K_STEPS) : 1,
    localparam int BW = (B_SUB_BLOCKS > 1) ? $clog2(B_SUB_BLOCKS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [UUID_W-1:0]    in_uuid,
    input  logic [WID_W-1:0]     in_wid,
    input  logic [3:0]           in_fmt_s,
    input  logic [3:0]           in_fmt_d,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [UUID_W-1:0]    out_uuid,
    output logic [WID_W-1:0]     out_wid,
    output logic [3:0]           out_fmt_s,
    output logic [3:0]           out_fmt_d,
    output logic [MW-1:0]        out_step_m,
    output logic [NW-1:0]        out_step_n,
    output logic [KW-1:0]        out_step_k,
    output logic [TCU_IDX_W-1:0] out_rs1,
    output logic [TCU_IDX_W-1:0] out_rs2,
    output logic [BW-1:0]        out_b_sub,
    output logic [TCU_IDX_W-1:0] out_rd,
    output logic                 out_first,
    output logic                 out_last
);

    seq_state_e r_state;
    seq_state_e w_state_nxt;

    logic [UUID_W-1:0] r_uuid;
    logic [WID_W-1:0]  r_wid;
    logic [3:0]        r_fmt_s;
    logic [3:0]        r_fmt_d;
    tcu_uop_t          r_uop;
    tcu_uop_t          w_uop;

    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_done;
    logic          w_ctr_last;
    logic [MW-1:0] w_m_nxt;
    logic [NW-1:0] w_n_nxt;
    logic [KW-1:0] w_k_nxt;
    logic [31:0]   w_rs1_full;
    logic [31:0]   w_bidx;
    logic [31:0]   w_rs2_full;
    logic [31:0]   w_bsub_full;
    logic [31:0]   w_rd_full;
    logic          w_unused;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_done     = w_out_fire && w_ctr_last;

    vx_tcu_step_ctr #(
        .M_STEPS (M_STEPS),
        .N_STEPS (N_STEPS),
        .K_STEPS (K_STEPS)
    ) u_step_ctr (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_in_fire),
        .i_advance (w_out_fire),
        .o_m_nxt   (w_m_nxt),
        .o_n_nxt   (w_n_nxt),
        .o_k_nxt   (w_k_nxt),
        .o_last    (w_ctr_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accepting the last micro-op together with a new instruction keeps BUSY.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SEQ_IDLE: if (w_in_fire)              w_state_nxt = SEQ_BUSY;
            SEQ_BUSY: if (w_done && !w_in_fire)   w_state_nxt = SEQ_IDLE;
            default:                              w_state_nxt = SEQ_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state == SEQ_BUSY);
        in_ready  = (r_state == SEQ_IDLE) || w_done;
    end

    // Micro-op fields are computed from the counter's next position so the
    // record can be registered in the same edge the counter moves.
    assign w_rs1_full  = 32'(RA) + 32'(w_m_nxt) * 32'(K_STEPS) + 32'(w_k_nxt);
    assign w_bidx      = 32'(w_k_nxt) * 32'(N_STEPS) + 32'(w_n_nxt);
    assign w_rs2_full  = 32'(RB) + w_bidx / 32'(B_SUB_BLOCKS);
    assign w_bsub_full = w_bidx % 32'(B_SUB_BLOCKS);
    assign w_rd_full   = 32'(RC) + 32'(w_m_nxt) * 32'(N_STEPS) + 32'(w_n_nxt);

    always_comb begin
        w_uop        = '0;
        w_uop.step_m = TCU_STEP_W'(w_m_nxt);
        w_uop.step_n = TCU_STEP_W'(w_n_nxt);
        w_uop.step_k = TCU_STEP_W'(w_k_nxt);
        w_uop.rs1    = TCU_IDX_W'(w_rs1_full);
        w_uop.rs2    = TCU_IDX_W'(w_rs2_full);
        w_uop.b_sub  = TCU_BSUB_W'(w_bsub_full);
        w_uop.rd     = TCU_IDX_W'(w_rd_full);
        w_uop.first  = (w_k_nxt == '0);
        w_uop.last   = (w_m_nxt == MW'(M_STEPS - 1)) &&
                       (w_n_nxt == NW'(N_STEPS - 1)) &&
                       (w_k_nxt == KW'(K_STEPS - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_uuid  <= '0;
            r_wid   <= '0;
            r_fmt_s <= '0;
            r_fmt_d <= '0;
            r_uop   <= '0;
        end else begin
            if (w_in_fire) begin
                r_uuid  <= in_uuid;
                r_wid   <= in_wid;
                r_fmt_s <= in_fmt_s;
                r_fmt_d <= in_fmt_d;
            end
            if (w_in_fire || w_out_fire) begin
                r_uop <= w_uop;
            end
        end
    end

    assign out_uuid   = r_uuid;
    assign out_wid    = r_wid;
    assign out_fmt_s  = r_fmt_s;
    assign out_fmt_d  = r_fmt_d;
    assign out_step_m = r_uop.step_m[MW-1:0];
    assign out_step_n = r_uop.step_n[NW-1:0];
    assign out_step_k = r_uop.step_k[KW-1:0];
    assign out_rs1    = r_uop.rs1;
    assign out_rs2    = r_uop.rs2;
    assign out_b_sub  = r_uop.b_sub[BW-1:0];
    assign out_rd     = r_uop.rd;
    assign out_first  = r_uop.first;
    assign out_last   = r_uop.last;

    // Record padding and the high bits of the 32-bit index sums are dropped.
    assign w_unused = ^{r_uop, w_rs1_full, w_rs2_full, w_bsub_full, w_rd_full};

endmodule

// File: tb/tb_vx_tcu_uop_seq.sv
// tb/tb_vx_tcu_uop_seq.sv - directed self-checking bench for vx_tcu_uop_seq
module tb_vx_tcu_uop_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [43:0] in_uuid, out_uuid;
    logic [1:0]  in_wid, out_wid;
    logic [3:0]  in_fmt_s, in_fmt_d, out_fmt_s, out_fmt_d;
    logic [0:0]  out_step_m;
    logic [1:0]  out_step_n, out_step_k;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [0:0]  out_b_sub;
    logic        out_first, out_last;

    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [43:0] d_in_uuid, d_out_uuid;
    logic [1:0]  d_in_wid, d_out_wid;
    logic [3:0]  d_out_fmt_s, d_out_fmt_d;
    logic [0:0]  d_step_m, d_step_n, d_step_k, d_b_sub;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic        d_first, d_last;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    vx_tcu_uop_seq u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_uuid(in_uuid), .in_wid(in_wid), .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_uuid(out_uuid), .out_wid(out_wid), .out_fmt_s(out_fmt_s), .out_fmt_d(out_fmt_d),
        .out_step_m(out_step_m), .out_step_n(out_step_n), .out_step_k(out_step_k),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_b_sub(out_b_sub), .out_rd(out_rd),
        .out_first(out_first), .out_last(out_last)
    );

    vx_tcu_uop_seq #(.M_STEPS(1), .N_STEPS(1), .K_STEPS(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_uuid(d_in_uuid), .in_wid(d_in_wid), .in_fmt_s(4'h7), .in_fmt_d(4'h8),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_uuid(d_out_uuid), .out_wid(d_out_wid), .out_fmt_s(d_out_fmt_s), .out_fmt_d(d_out_fmt_d),
        .out_step_m(d_step_m), .out_step_n(d_step_n), .out_step_k(d_step_k),
        .out_rs1(d_rs1), .out_rs2(d_rs2), .out_b_sub(d_b_sub), .out_rd(d_rd),
        .out_first(d_first), .out_last(d_last)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected micro-op i of a 2x4x4 instruction: k fastest, then n, then m.
    task automatic check_uop(input string t, input int i, input logic [43:0] uuid);
        int k, n, m, bi;
        k  = i % 4;
        n  = (i / 4) % 4;
        m  = i / 16;
        bi = k * 4 + n;
        chk($sformatf("%s.u%0d.valid", t, i), 64'(out_valid), 64'(1));
        chk($sformatf("%s.u%0d.uuid", t, i),  64'(out_uuid), 64'(uuid));
        chk($sformatf("%s.u%0d.m", t, i),     64'(out_step_m), 64'(m));
        chk($sformatf("%s.u%0d.n", t, i),     64'(out_step_n), 64'(n));
        chk($sformatf("%s.u%0d.k", t, i),     64'(out_step_k), 64'(k));
        chk($sformatf("%s.u%0d.rs1", t, i),   64'(out_rs1), 64'(m * 4 + k));
        chk($sformatf("%s.u%0d.rs2", t, i),   64'(out_rs2), 64'(10 + bi / 2));
        chk($sformatf("%s.u%0d.bsub", t, i),  64'(out_b_sub), 64'(bi % 2));
        chk($sformatf("%s.u%0d.rd", t, i),    64'(out_rd), 64'(24 + m * 4 + n));
        chk($sformatf("%s.u%0d.first", t, i), 64'(out_first), 64'(k == 0));
        chk($sformatf("%s.u%0d.last", t, i),  64'(out_last), 64'(i == 31));
    endtask

    initial begin
        int idx;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_uuid = '0; in_wid = '0; in_fmt_s = '0; in_fmt_d = '0;
        d_in_valid = 1'b0; d_out_ready = 1'b0; d_in_uuid = '0; d_in_wid = '0;
        tick(); tick();

        chk("rst.valid", 64'(out_valid), 64'(0));
        chk("rst.in_ready", 64'(in_ready), 64'(1));
        chk("rst.uuid", 64'(out_uuid), 64'(0));
        chk("rst.rd", 64'(out_rd), 64'(0));
        chk("rst.rs2", 64'(out_rs2), 64'(0));
        chk("rst.d_valid", 64'(d_out_valid), 64'(0));
        reset = 1'b0;

        // single instruction, full-rate drain
        in_valid = 1'b1; in_uuid = 44'hABC_1234_5678; in_wid = 2'd1;
        in_fmt_s = 4'd3; in_fmt_d = 4'd5; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check_uop("t1", i, 44'hABC_1234_5678);
            chk($sformatf("t1.u%0d.in_ready", i), 64'(in_ready), 64'(i == 31));
            if (i == 0) begin
                chk("t1.wid", 64'(out_wid), 64'(1));
                chk("t1.fmt_s", 64'(out_fmt_s), 64'(3));
                chk("t1.fmt_d", 64'(out_fmt_d), 64'(5));
            end
            if (i == 1) chk("t1.u1.rs2.hand", 64'(out_rs2), 64'(12));
            if (i == 31) begin
                chk("t1.u31.rs1.hand", 64'(out_rs1), 64'(7));
                chk("t1.u31.rs2.hand", 64'(out_rs2), 64'(17));
                chk("t1.u31.rd.hand", 64'(out_rd), 64'(31));
            end
            tick();
        end
        chk("t1.idle.valid", 64'(out_valid), 64'(0));
        chk("t1.idle.in_ready", 64'(in_ready), 64'(1));

        // random backpressure: sequence must match with no skip or repeat
        in_valid = 1'b1; in_uuid = 44'h0000_0000_BEEF; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 600 && idx < 32; cyc++) begin
            check_uop("t2", idx, 44'h0000_0000_BEEF);
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (out_ready) idx++;
        end
        chk("t2.count", 64'(idx), 64'(32));
        chk("t2.idle.valid", 64'(out_valid), 64'(0));

        // back-to-back with in_valid held; the waiting instruction must not
        // disturb the in-flight fields
        in_valid = 1'b1; in_uuid = 44'h111_1111_1111; in_wid = 2'd2; out_ready = 1'b1;
        tick();
        in_uuid = 44'h222_2222_2222; in_wid = 2'd3; in_fmt_s = 4'd9;
        for (int i = 0; i < 32; i++) begin
            check_uop("t3a", i, 44'h111_1111_1111);
            chk($sformatf("t3a.u%0d.wid", i), 64'(out_wid), 64'(2));
            chk($sformatf("t3a.u%0d.fmt_s", i), 64'(out_fmt_s), 64'(3));
            chk($sformatf("t3a.u%0d.in_ready", i), 64'(in_ready), 64'(i == 31));
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check_uop("t3b", i, 44'h222_2222_2222);
            chk($sformatf("t3b.u%0d.wid", i), 64'(out_wid), 64'(3));
            tick();
        end
        chk("t3.idle.valid", 64'(out_valid), 64'(0));

        // reset in the middle of an instruction
        in_valid = 1'b1; in_uuid = 44'h333_0000_0005;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_uop("t4", 10, 44'h333_0000_0005);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4.rst.valid", 64'(out_valid), 64'(0));
        chk("t4.rst.in_ready", 64'(in_ready), 64'(1));
        chk("t4.rst.uuid", 64'(out_uuid), 64'(0));
        in_valid = 1'b1; in_uuid = 44'h444_0000_0006;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check_uop("t4b", i, 44'h444_0000_0006);
            tick();
        end
        chk("t4b.idle.valid", 64'(out_valid), 64'(0));

        // degenerate 1x1x1 instance
        chk("t5.in_ready0", 64'(d_in_ready), 64'(1));
        d_in_valid = 1'b1; d_in_uuid = 44'h555_5555_5555; d_in_wid = 2'd2;
        tick();
        d_in_valid = 1'b0;
        chk("t5.valid", 64'(d_out_valid), 64'(1));
        chk("t5.uuid", 64'(d_out_uuid), 64'h555_5555_5555);
        chk("t5.wid", 64'(d_out_wid), 64'(2));
        chk("t5.fmt", 64'({d_out_fmt_s, d_out_fmt_d}), 64'h78);
        chk("t5.steps", 64'({d_step_m, d_step_n, d_step_k, d_b_sub}), 64'(0));
        chk("t5.rs1", 64'(d_rs1), 64'(0));
        chk("t5.rs2", 64'(d_rs2), 64'(10));
        chk("t5.rd", 64'(d_rd), 64'(24));
        chk("t5.first", 64'(d_first), 64'(1));
        chk("t5.last", 64'(d_last), 64'(1));
        chk("t5.in_ready.stall", 64'(d_in_ready), 64'(0));
        tick();
        chk("t5.hold.valid", 64'(d_out_valid), 64'(1));
        chk("t5.hold.last", 64'(d_last), 64'(1));
        chk("t5.hold.in_ready", 64'(d_in_ready), 64'(1 & d_out_ready));
        d_out_ready = 1'b1;
        tick();
        chk("t5.idle.valid", 64'(d_out_valid), 64'(0));
        chk("t5.idle.in_ready", 64'(d_in_ready), 64'(1));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
